// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch front end.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_ENCODING = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory port, redirect input and decode-stage handshake.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;
    logic            fetch_fault;
    logic [XLEN-1:0] fetch_count;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault, fetch_count,
        input  imem_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault, fetch_count,
        output imem_data, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register with hold / +4 / redirect next-PC selection.
module fetch_pc_gen
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_sel_t         sel_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + XLEN'(4);

    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_INC:   pc_d = pc_plus4_o;
            PC_REDIR: pc_d = redirect_pc_i;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: boot/run/fault control, decode output register and handshake counter.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    fetch_state_t    state_q;
    logic            valid_q;
    logic            fault_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] id_pc4_q;
    logic [XLEN-1:0] count_q;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            handshake;
    logic            load;
    pc_sel_t         pc_sel;

    assign handshake = valid_q && bus.id_ready;
    assign load      = (state_q == RUN) && (!valid_q || bus.id_ready);

    // Redirect wins over load and stall in every state.
    always_comb begin
        pc_sel = PC_HOLD;
        if (bus.redirect_valid) begin
            pc_sel = PC_REDIR;
        end else if (load) begin
            pc_sel = PC_INC;
        end
    end

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .sel_i         (pc_sel),
        .redirect_pc_i (bus.redirect_pc),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            id_pc_q  <= '0;
            id_pc4_q <= '0;
            count_q  <= '0;
        end else begin
            // A handshake coinciding with a redirect is still counted.
            if (handshake) begin
                count_q <= count_q + XLEN'(1);
            end
            if (bus.redirect_valid) begin
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
                if (is_word_aligned(bus.redirect_pc)) begin
                    state_q <= RUN;
                    fault_q <= 1'b0;
                end else begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    BOOT: state_q <= RUN;
                    RUN: begin
                        if (load) begin
                            valid_q  <= 1'b1;
                            instr_q  <= bus.imem_data;
                            id_pc_q  <= pc;
                            id_pc4_q <= pc_plus4;
                        end
                    end
                    default: begin
                        valid_q <= 1'b0;
                        fault_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.id_valid    = valid_q;
    assign bus.id_instr    = instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc4_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013: instruction presented on id_instr when the output is not valid.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_addr  output  32: byte address to the combinational instruction memory, equal to the PC register.
REQ-006 SHALL have port imem_data  input  32: instruction word returned by memory in the same cycle as imem_addr.
REQ-007 SHALL have port redirect_valid  input  1: branch/jump taken; flush and refetch.
REQ-008 SHALL have port redirect_pc  input  32: redirect target byte address.
REQ-009 SHALL have port id_ready  input  1: decode accepts id_instr this cycle.
REQ-010 SHALL have port id_valid  output  1: id_instr, id_pc and id_pc_plus4 hold a fetched instruction.
REQ-011 SHALL have port id_instr  output  32: fetched instruction word.
REQ-012 SHALL have port id_pc  output  32: address of id_instr.
REQ-013 SHALL have port id_pc_plus4  output  32: id_pc + 4, modulo 2^32.
REQ-014 SHALL have port fetch_fault  output  1: high while in state FAULT.
REQ-015 SHALL have port fetch_count  output  32: number of handshakes where id_valid && id_ready, wrapping.

Function
REQ-016 SHALL implement states BOOT, RUN and FAULT.
REQ-017 BOOT SHALL last exactly one cycle after reset release, then move to RUN with no output; it gives memory initialisation one cycle.
REQ-018 In RUN, the output register SHALL load when !id_valid || id_ready: id_instr<=imem_data, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
REQ-019 If id_valid && !id_ready, id_instr, id_pc, id_pc_plus4 and pc SHALL hold (stall); data SHALL be stable while valid and not accepted.
REQ-020 A redirect_valid cycle SHALL take priority over stall and load in any state: id_valid<=0, id_instr<=NOP_INSTR, pc<=redirect_pc; no instruction SHALL be captured that cycle.
REQ-021 Fetch resumes at redirect_pc on the cycle after the redirect; first valid output SHALL appear 2 cycles after the redirect edge.
REQ-022 If redirect_pc[1:0] != 0, the block SHALL enter FAULT, hold id_valid=0 and fetch_fault=1, and leave only on an aligned redirect (to RUN) or reset.
REQ-023 Redirect plus handshake in the same cycle: the handshake SHALL count in fetch_count, and the output SHALL still flush.
REQ-024 PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without fault.
REQ-025 When !id_valid, id_instr SHALL equal NOP_INSTR.
REQ-026 fetch_count SHALL increment by 1 per accepted handshake and wrap 32'hFFFF_FFFF -> 0.

Reset
REQ-027 rst_n low SHALL immediately force: state=BOOT, pc=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, fetch_fault=0, fetch_count=0.
REQ-028 Reset asserted mid-stall or mid-FAULT SHALL discard all pending state; first valid output SHALL be the instruction at RESET_PC, 2 cycles after rst_n rises.

Structure
REQ-029 riscv_pkg SHALL hold XLEN=32, the NOP encoding constant, and fetch_state_t (BOOT/RUN/FAULT).
REQ-030 The PC register with next-PC select (hold / +4 / redirect) SHALL be sub-module fetch_pc_gen; output register, FSM and counter stay in fetch_unit.

Verification
REQ-031 Reset with memory {0:00000f93, 4:00f00313, 8:001f8f93} and id_ready=1 -> id_valid rises at cycle 2; id_pc sequence 0,4,8; id_instr matches memory.
REQ-032 id_ready held low 3 cycles while id_valid=1 (id_pc=4) -> outputs frozen at 4/00f00313; on release next id_pc=8; fetch_count advances only on accepted cycles.
REQ-033 redirect_valid=1 with redirect_pc=0x18 while stalled -> next cycle id_valid=0, id_instr=00000013; following cycle id_pc=0x18, id_pc_plus4=0x1C.
REQ-034 redirect_pc=0x22 -> fetch_fault=1, id_valid stays 0 over 5 cycles; redirect_pc=0x10 -> fault clears, id_pc=0x10 valid 2 cycles later.
REQ-035 redirect_pc=0xFFFFFFFC -> id_pc 0xFFFFFFFC with id_pc_plus4=0, then id_pc=0, fetch_fault=0.
REQ-036 rst_n pulsed low between clock edges during a stall -> outputs clear asynchronously; refetch starts at RESET_PC.
